// File: rtl/action_determiner_core_pkg.sv
// ----------------------------------------------------------------------------
// q_pkg
// Shared types and constants for the epsilon-greedy action determiner.
//   DATA_W     : width of the signed Q-values
//   ITER_W     : width of the iteration counters
//   LFSR_SEED  : nonzero reset value of the 16-bit exploration LFSR
//   LFSR_TAPS  : feedback mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   action_t   : 2-bit action code, ACT_0..ACT_3
//   lfsr_next  : one Fibonacci step of the LFSR (shift left, feedback into bit 0)
// ----------------------------------------------------------------------------
package q_pkg;

    localparam int          DATA_W    = 32;
    localparam int          ITER_W    = 12;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ACT_0 = 2'd0,
        ACT_1 = 2'd1,
        ACT_2 = 2'd2,
        ACT_3 = 2'd3
    } action_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/action_determiner_core_if.sv
// ----------------------------------------------------------------------------
// action_determiner_core_if
// Groups the per-cycle data bus of the action determiner.
//   iteration, total_iteration : unsigned iteration index / planned total
//   Q_max                      : signed maximum Q-value of the current state
//   in0..in3                   : signed Q-values for actions 0..3
//   act                        : selected action (registered in the core)
// Modports: master drives the Q-values and counters, slave returns act.
// ----------------------------------------------------------------------------
interface action_determiner_core_if;
    import q_pkg::*;

    logic        [ITER_W-1:0] iteration;
    logic        [ITER_W-1:0] total_iteration;
    logic signed [DATA_W-1:0] Q_max;
    logic signed [DATA_W-1:0] in0;
    logic signed [DATA_W-1:0] in1;
    logic signed [DATA_W-1:0] in2;
    logic signed [DATA_W-1:0] in3;
    action_t                  act;

    modport master (
        output iteration, total_iteration, Q_max, in0, in1, in2, in3,
        input  act
    );

    modport slave (
        input  iteration, total_iteration, Q_max, in0, in1, in2, in3,
        output act
    );

endinterface

// File: rtl/action_determiner_core_lfsr16.sv
// ----------------------------------------------------------------------------
// q_lfsr16
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) used as the exploration
// randomness source. Only built when ACTDET_EXPLORE_EN is defined; the pure
// greedy build has no use for it.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, loads SEED
//   en   : advance one step per clock when high
//   lfsr : current LFSR state
// A nonzero seed keeps the register out of the all-zero lock-up state.
// ----------------------------------------------------------------------------
`ifdef ACTDET_EXPLORE_EN
module q_lfsr16
    import q_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_d;
    logic [15:0] lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule
`endif

// File: rtl/action_determiner_core.sv
// ----------------------------------------------------------------------------
// action_determiner_core
// Epsilon-greedy action selector: one of four actions per clock, registered.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (act -> 0, LFSR -> seed)
//   bus : action_determiner_core_if.slave (iteration, total_iteration,
//         Q_max, in0..in3 in; act out)
// Greedy action: first input equal to Q_max (priority 0..3); if none match,
// the signed argmax with ties to the lowest index.
// Macro ACTDET_EXPLORE_EN: when defined, an LFSR-driven explore path replaces
// the greedy choice with probability (total-iteration)/total, tested as
// r*total < rem<<12 so no divider is needed. When undefined, act is purely
// greedy and neither the LFSR nor the multiplier exists.
// ----------------------------------------------------------------------------
module action_determiner_core
    import q_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic                    clk,
    input  logic                    rst,
    action_determiner_core_if.slave bus
);

    logic signed [DATA_W-1:0] q_in [4];
    logic signed [DATA_W-1:0] best_q;
    logic                     found;
    action_t                  greedy_act;
    action_t                  act_d;
    action_t                  act_q;

    always_comb begin
        q_in[0] = bus.in0;
        q_in[1] = bus.in1;
        q_in[2] = bus.in2;
        q_in[3] = bus.in3;
    end

    // Exact match wins first; strict '>' in the argmax keeps ties on the
    // lowest index.
    always_comb begin
        greedy_act = ACT_0;
        found      = 1'b0;
        best_q     = q_in[0];
        for (int i = 0; i < 4; i++) begin
            if (!found && (q_in[i] == bus.Q_max)) begin
                greedy_act = action_t'(i[1:0]);
                found      = 1'b1;
            end
        end
        if (!found) begin
            greedy_act = ACT_0;
            for (int i = 1; i < 4; i++) begin
                if (q_in[i] > best_q) begin
                    best_q     = q_in[i];
                    greedy_act = action_t'(i[1:0]);
                end
            end
        end
    end

`ifdef ACTDET_EXPLORE_EN
    localparam int PROD_W = 2 * ITER_W + 1;

    logic [15:0]       lfsr;
    logic [ITER_W-1:0] rem;
    logic [PROD_W-1:0] lhs;
    logic [PROD_W-1:0] rhs;
    logic              explore;
    logic              unused_lfsr_bits;

    q_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .lfsr (lfsr)
    );

    assign unused_lfsr_bits = ^lfsr[13:12];

    // Explore with probability rem/total: r is uniform over 0..4095, so
    // r*total < rem*4096 compares the sample against the scaled threshold.
    // iteration==0 gives rem==total, which always holds since r < 4096.
    always_comb begin
        rem = '0;
        if (bus.iteration < bus.total_iteration) begin
            rem = bus.total_iteration - bus.iteration;
        end
        lhs     = PROD_W'(lfsr[11:0]) * PROD_W'(bus.total_iteration);
        rhs     = PROD_W'(rem) << 12;
        explore = (bus.total_iteration != '0) && (lhs < rhs);
        act_d   = explore ? action_t'(lfsr[15:14]) : greedy_act;
    end
`else
    logic [15:0] unused_seed;

    assign unused_seed = SEED;

    always_comb begin
        act_d = greedy_act;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= ACT_0;
        end else begin
            act_q <= act_d;
        end
    end

    assign bus.act = act_q;

endmodule

// File: tb/tb_action_determiner_core.sv
// ----------------------------------------------------------------------------
// tb_action_determiner_core
// Directed bench for action_determiner_core. Greedy vectors, reset and
// latency are checked in every build; with ACTDET_EXPLORE_EN defined the
// explore path is checked against a reference LFSR model as well.
// ----------------------------------------------------------------------------
module tb_action_determiner_core;
    import q_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    action_determiner_core_if bus ();

    action_determiner_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef ACTDET_EXPLORE_EN
    logic [15:0] m_lfsr;

    // Reference LFSR that tracks the DUT's stepping and reset behaviour.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end
`endif

    // Drive a full input vector just after a falling edge.
    task automatic applyStimulus(input logic [11:0] it, input logic [11:0] tot,
                                 input logic signed [31:0] qm,
                                 input logic signed [31:0] a, input logic signed [31:0] b,
                                 input logic signed [31:0] c, input logic signed [31:0] d);
        @(negedge clk);
        bus.iteration       = it;
        bus.total_iteration = tot;
        bus.Q_max           = qm;
        bus.in0             = a;
        bus.in1             = b;
        bus.in2             = c;
        bus.in3             = d;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] expected);
        n_total++;
        assert (bus.act === expected) else begin
            n_bad++;
            $error("[TB] FAIL %s: act=%0d expected=%0d", tag, bus.act, expected);
        end
    endtask

    task automatic stepCheck(input string tag, input logic [11:0] it, input logic [11:0] tot,
                             input logic signed [31:0] qm,
                             input logic signed [31:0] a, input logic signed [31:0] b,
                             input logic signed [31:0] c, input logic signed [31:0] d,
                             input logic [1:0] expected);
        applyStimulus(it, tot, qm, a, b, c, d);
        @(posedge clk);
        #1;
        checkOutput(tag, expected);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(12'd300, 12'd300, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0);
        #1;
        checkOutput("reset_state", 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // Greedy vectors (iteration >= total keeps the explore path off).
        stepCheck("match_in3",   12'd300, 12'd300, 32'sd0,  -32'sd50, -32'sd20, -32'sd10, 32'sd0,   2'd3);
        stepCheck("match_in2",   12'd400, 12'd300, 32'sd0,  -32'sd25, -32'sd37, 32'sd0,   -32'sd15, 2'd2);
        stepCheck("match_in0",   12'd300, 12'd300, 32'sd50, 32'sd50,  -32'sd20, -32'sd10, 32'sd0,   2'd0);
        stepCheck("match_in1",   12'd300, 12'd300, 32'sd50, 32'sd0,   32'sd50,  -32'sd30, 32'sd20,  2'd1);
        stepCheck("nomatch_tie", 12'd300, 12'd300, 32'sd99, 32'sd5,   32'sd7,   32'sd7,   -32'sd1,  2'd1);
        stepCheck("match_tie",   12'd300, 12'd300, -32'sd3, -32'sd3,  -32'sd3,  32'sd0,   32'sd0,   2'd0);
        stepCheck("match_not_max", 12'd300, 12'd300, 32'sd5, 32'sd1,  32'sd2,   32'sd5,   32'sd9,   2'd2);
        stepCheck("nomatch_neg", 12'd300, 12'd300, 32'sd100, -32'sd5, -32'sd9,  -32'sd2,  -32'sd7,  2'd2);
        stepCheck("signed_wide", 12'd300, 12'd300, 32'sd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'sd0, 32'sd5, 2'd1);
        stepCheck("full_width",  12'd300, 12'd300, 32'h0001_0003, 32'sd3, 32'h0002_0003, 32'h0001_0003, 32'h7FFF_FFFF, 2'd2);
        stepCheck("tie_upper",   12'd300, 12'd300, 32'sd100, 32'sd1,  32'sd2,   32'sd3,   32'sd3,   2'd2);
        stepCheck("total_zero",  12'd0,   12'd0,   32'sd7,  32'sd0,   32'sd0,   32'sd0,   32'sd7,   2'd3);
        stepCheck("total_zero_b", 12'd5,  12'd0,   32'sd99, 32'sd0,   32'sd4,   32'sd1,   32'sd2,   2'd1);

        // One-cycle latency: a new vector must not reach act before the edge.
        applyStimulus(12'd300, 12'd300, 32'sd50, 32'sd50, -32'sd20, -32'sd10, 32'sd0);
        #1;
        checkOutput("latency_hold", 2'd1);
        @(posedge clk);
        #1;
        checkOutput("latency_update", 2'd0);

        // Asynchronous reset in the middle of a cycle.
        stepCheck("pre_reset", 12'd300, 12'd300, 32'sd0, -32'sd50, -32'sd20, -32'sd10, 32'sd0, 2'd3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async", 2'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold", 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_release", 2'd3);

`ifdef ACTDET_EXPLORE_EN
        begin
            logic [1:0] exp_act;
            int         miss;

            // Reset reloads the seed: first explored action is seed[15:14] = 2.
            applyStimulus(12'd0, 12'd300, 32'sd50, 32'sd50, 32'sd0, 32'sd0, 32'sd0);
            #2;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("lfsr_reload", 2'd2);

            // iteration 0: every cycle explores.
            miss = 0;
            for (int k = 0; k < 64; k++) begin
                @(negedge clk);
                exp_act = m_lfsr[15:14];
                @(posedge clk);
                #1;
                if (bus.act !== exp_act) miss++;
            end
            n_total++;
            assert (miss == 0) else begin
                n_bad++;
                $error("[TB] FAIL explore_iter0: mismatching cycles=%0d expected=0", miss);
            end

            // iteration 150 of 300: explore when r*300 < 150*4096.
            applyStimulus(12'd150, 12'd300, 32'sd1, 32'sd0, 32'sd1, 32'sd0, 32'sd0);
            miss = 0;
            for (int k = 0; k < 4096; k++) begin
                if (k != 0) @(negedge clk);
                if ((32'(m_lfsr[11:0]) * 300) < (150 * 4096)) exp_act = m_lfsr[15:14];
                else exp_act = 2'd1;
                @(posedge clk);
                #1;
                if (bus.act !== exp_act) miss++;
            end
            n_total++;
            assert (miss == 0) else begin
                n_bad++;
                $error("[TB] FAIL explore_half: mismatching cycles=%0d expected=0", miss);
            end
        end
`else
        // Pure greedy build: iteration 0 must still follow the greedy choice.
        stepCheck("greedy_iter0", 12'd0, 12'd300, 32'sd50, 32'sd0, 32'sd0, 32'sd0, 32'sd50, 2'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
